// File: rtl/cluster_pkg.sv
// Shared types and constants for the cluster collector: slot layout, the
// invalid-slot encoding and the collector FSM states.
package cluster_pkg;

    localparam int ADR_W     = 11;
    localparam int CNT_W     = 3;
    localparam int CLUSTER_W = ADR_W + CNT_W;

    localparam logic [ADR_W-1:0] INVALID_ADR = 11'h7FF;

    typedef struct packed {
        logic [ADR_W-1:0] adr;
        logic [CNT_W-1:0] cnt;
    } cluster_t;

    localparam cluster_t INVALID_CLUSTER = '{adr: INVALID_ADR, cnt: 3'h0};

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc and holds once it reaches all-ones.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else if (inc && (count_q != {WIDTH{1'b1}})) begin
            count_q <= count_q + WIDTH'(1);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/cluster_collector.sv
// Gathers per-pass encoder results into one cluster frame per bunch crossing
// and hands it out over valid/ready. Optional CLUSTER_EARLY_DONE_EN ends a frame
// at the first empty pass and silently drains the rest of that crossing.
module cluster_collector
    import cluster_pkg::*;
#(
    parameter int MXCLUSTERS = 8,
    parameter int MXADRBITS  = 11,
    parameter int MXCNTBITS  = 3,
    parameter int ERRBITS    = 8
) (
    input  logic                            clock,
    input  logic                            reset_n,
    input  logic                            cluster_valid,
    input  logic                            cluster_found,
    input  logic [MXADRBITS-1:0]            adr,
    input  logic [MXCNTBITS-1:0]            cnt,
    input  logic [2:0]                      pass_in,
    input  logic                            frame_ready,
    output logic                            frame_valid,
    output logic [MXCLUSTERS*CLUSTER_W-1:0] frame_data,
    output logic [3:0]                      frame_nclusters,
    output logic [ERRBITS-1:0]              overflow_cnt,
    output logic [ERRBITS-1:0]              seq_err_cnt
);

    localparam logic [2:0] LAST_PASS = 3'(MXCLUSTERS - 1);

    state_t   state_q, state_d;
    logic [2:0] exp_q, exp_d;
    logic [3:0] nclus_q, nclus_d;
    cluster_t buf_q [MXCLUSTERS];
    cluster_t buf_d [MXCLUSTERS];

    logic [MXCLUSTERS*CLUSTER_W-1:0] frame_q, frame_d;
    logic [3:0] nout_q;
    logic       valid_q;

    cluster_t new_slot;
    logic do_start, do_append, early_done, drain_q;
    logic complete, seq_inc, ovf_inc, transfer;

`ifdef CLUSTER_EARLY_DONE_EN
    assign early_done = !cluster_found;

    // Set when a frame ends early so the tail of that crossing is swallowed.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            drain_q <= 1'b0;
        end else if (complete && early_done) begin
            drain_q <= 1'b1;
        end else if (do_start) begin
            drain_q <= 1'b0;
        end
    end
`else
    assign early_done = 1'b0;
    assign drain_q    = 1'b0;
`endif

    // exp_q is never 0 while collecting, so a pass-0 result always (re)starts.
    assign do_start  = cluster_valid && (pass_in == 3'd0);
    assign do_append = cluster_valid && (state_q == COLLECT) && (pass_in == exp_q);
    assign seq_inc   = cluster_valid &&
                       (((state_q == COLLECT) && (pass_in != exp_q)) ||
                        ((state_q == IDLE) && (pass_in != 3'd0) && !drain_q));
    assign complete  = (do_start && ((MXCLUSTERS == 1) || early_done)) ||
                       (do_append && ((pass_in == LAST_PASS) || early_done));

    always_comb begin
        new_slot = INVALID_CLUSTER;
        if (cluster_found) begin
            new_slot.adr = adr;
            new_slot.cnt = cnt;
        end
    end

    always_comb begin
        state_d = state_q;
        exp_d   = exp_q;
        nclus_d = nclus_q;
        for (int i = 0; i < MXCLUSTERS; i++) begin
            buf_d[i] = buf_q[i];
        end
        if (do_start) begin
            for (int i = 0; i < MXCLUSTERS; i++) begin
                buf_d[i] = INVALID_CLUSTER;
            end
            buf_d[0] = new_slot;
            nclus_d  = {3'b000, cluster_found};
            exp_d    = 3'd1;
            state_d  = COLLECT;
        end else if (do_append) begin
            for (int i = 0; i < MXCLUSTERS; i++) begin
                if (3'(i) == pass_in) begin
                    buf_d[i] = new_slot;
                end
            end
            nclus_d = nclus_q + {3'b000, cluster_found};
            exp_d   = exp_q + 3'd1;
        end else if (cluster_valid && (state_q == COLLECT)) begin
            state_d = IDLE;
            exp_d   = 3'd0;
        end
        if (complete) begin
            state_d = IDLE;
            exp_d   = 3'd0;
        end
    end

    for (genvar gi = 0; gi < MXCLUSTERS; gi++) begin : g_pack
        assign frame_d[gi*CLUSTER_W +: CLUSTER_W] = buf_d[gi];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            exp_q   <= 3'd0;
            nclus_q <= 4'd0;
            for (int i = 0; i < MXCLUSTERS; i++) begin
                buf_q[i] <= INVALID_CLUSTER;
            end
        end else begin
            state_q <= state_d;
            exp_q   <= exp_d;
            nclus_q <= nclus_d;
            for (int i = 0; i < MXCLUSTERS; i++) begin
                buf_q[i] <= buf_d[i];
            end
        end
    end

    assign transfer = valid_q && frame_ready;
    assign ovf_inc  = complete && valid_q && !frame_ready;

    // A held frame is never overwritten; a completion racing a transfer wins the slot.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            frame_q <= {MXCLUSTERS{INVALID_CLUSTER}};
            nout_q  <= 4'd0;
        end else if (complete && !ovf_inc) begin
            valid_q <= 1'b1;
            frame_q <= frame_d;
            nout_q  <= nclus_d;
        end else if (transfer) begin
            valid_q <= 1'b0;
        end
    end

    assign frame_valid     = valid_q;
    assign frame_data      = frame_q;
    assign frame_nclusters = nout_q;

    sat_counter #(.WIDTH(ERRBITS)) u_overflow_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .inc     (ovf_inc),
        .count   (overflow_cnt)
    );

    sat_counter #(.WIDTH(ERRBITS)) u_seq_err_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .inc     (seq_inc),
        .count   (seq_err_cnt)
    );

endmodule

// File: tb/tb_cluster_collector.sv
// Directed self-checking bench for cluster_collector (MXCLUSTERS=8): full,
// sparse, backpressure, sequence-error, saturation and reset scenarios.
module tb_cluster_collector;

    localparam int MXC = 8;
    localparam int FW  = MXC * 14;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          cluster_valid = 1'b0;
    logic          cluster_found = 1'b0;
    logic [10:0]   adr = 11'd0;
    logic [2:0]    cnt = 3'd0;
    logic [2:0]    pass_in = 3'd0;
    logic          frame_ready = 1'b0;
    logic          frame_valid;
    logic [FW-1:0] frame_data;
    logic [3:0]    frame_nclusters;
    logic [7:0]    overflow_cnt;
    logic [7:0]    seq_err_cnt;

    int checks = 0;
    int errors = 0;

    cluster_collector #(
        .MXCLUSTERS (MXC),
        .MXADRBITS  (11),
        .MXCNTBITS  (3),
        .ERRBITS    (8)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .cluster_valid   (cluster_valid),
        .cluster_found   (cluster_found),
        .adr             (adr),
        .cnt             (cnt),
        .pass_in         (pass_in),
        .frame_ready     (frame_ready),
        .frame_valid     (frame_valid),
        .frame_data      (frame_data),
        .frame_nclusters (frame_nclusters),
        .overflow_cnt    (overflow_cnt),
        .seq_err_cnt     (seq_err_cnt)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end else begin
            $display("ok   %s = %h", tag, obs);
        end
    endtask

    task automatic send(input int p, input bit f, input int a, input int c);
        @(negedge clock);
        cluster_valid = 1'b1;
        pass_in       = 3'(p);
        cluster_found = f;
        adr           = f ? 11'(a) : 11'h7FF;
        cnt           = f ? 3'(c) : 3'd0;
    endtask

    task automatic idle();
        @(negedge clock);
        cluster_valid = 1'b0;
        cluster_found = 1'b0;
    endtask

    task automatic send_frame(input int base, input int step);
        for (int k = 0; k < MXC; k++) send(k, 1'b1, base + step * k, k);
        idle();
    endtask

    function automatic logic [FW-1:0] inv_frame();
        logic [FW-1:0] f;
        for (int k = 0; k < MXC; k++) f[k*14 +: 14] = 14'h3FF8;
        return f;
    endfunction

    function automatic logic [FW-1:0] exp_frame(input int base, input int step);
        logic [FW-1:0] f;
        for (int k = 0; k < MXC; k++) f[k*14 +: 14] = {11'(base + step * k), 3'(k)};
        return f;
    endfunction

    logic [FW-1:0] sparse;

    initial begin
        repeat (2) @(negedge clock);
        check_val("reset_valid", frame_valid, 0);
        check_val("reset_data", frame_data, inv_frame());
        check_val("reset_ncl", frame_nclusters, 0);
        check_val("reset_ovf", overflow_cnt, 0);
        check_val("reset_seq", seq_err_cnt, 0);
        reset_n = 1'b1;
        frame_ready = 1'b1;

        // Full frame: adr=10k, cnt=k.
        for (int k = 0; k < 7; k++) send(k, 1'b1, 10 * k, k);
        check_val("full_not_early", frame_valid, 0);
        send(7, 1'b1, 70, 7);
        idle();
        check_val("full_valid", frame_valid, 1);
        check_val("full_slot3", frame_data[55:42], 14'h00F3);
        check_val("full_data", frame_data, exp_frame(0, 10));
        check_val("full_ncl", frame_nclusters, 8);
        @(negedge clock);
        check_val("full_pulse_end", frame_valid, 0);

        // Sparse: found only on passes 0 and 1.
        sparse = inv_frame();
        sparse[13:0]  = 14'h0029;
        sparse[27:14] = 14'h15E2;
        send(0, 1'b1, 5, 1);
        send(1, 1'b1, 700, 2);
`ifdef CLUSTER_EARLY_DONE_EN
        send(2, 1'b0, 0, 0);
        idle();
        check_val("sparse_early_valid", frame_valid, 1);
        check_val("sparse_data", frame_data, sparse);
        check_val("sparse_ncl", frame_nclusters, 2);
        for (int k = 3; k < MXC; k++) send(k, 1'b0, 0, 0);
        idle();
`else
        for (int k = 2; k < MXC; k++) send(k, 1'b0, 0, 0);
        idle();
        check_val("sparse_valid", frame_valid, 1);
        check_val("sparse_data", frame_data, sparse);
        check_val("sparse_ncl", frame_nclusters, 2);
`endif
        check_val("sparse_seq", seq_err_cnt, 0);

        // Backpressure: A held, B dropped, C loads on the transfer edge.
        @(negedge clock);
        frame_ready = 1'b0;
        send_frame(100, 1);
        check_val("bp_a_valid", frame_valid, 1);
        send_frame(200, 1);
        check_val("bp_ovf1", overflow_cnt, 1);
        check_val("bp_a_held", frame_data, exp_frame(100, 1));
        for (int k = 0; k < 7; k++) send(k, 1'b1, 300 + k, k);
        send(7, 1'b1, 307, 7);
        frame_ready = 1'b1;
        @(negedge clock);
        cluster_valid = 1'b0;
        frame_ready = 1'b0;
        check_val("bp_c_valid", frame_valid, 1);
        check_val("bp_c_data", frame_data, exp_frame(300, 1));
        check_val("bp_ovf_kept", overflow_cnt, 1);
        frame_ready = 1'b1;
        @(negedge clock);
        check_val("bp_drained", frame_valid, 0);

        // Sequence errors: 0,1,3 then 0,1,0..7.
        send(0, 1'b1, 1, 1);
        send(1, 1'b1, 2, 2);
        send(3, 1'b1, 3, 3);
        idle();
        check_val("seq_err1", seq_err_cnt, 1);
        check_val("seq_no_frame", frame_valid, 0);
        send(0, 1'b1, 9, 1);
        send(1, 1'b1, 9, 2);
        send_frame(400, 1);
        check_val("seq_err2", seq_err_cnt, 2);
        check_val("seq_restart_valid", frame_valid, 1);
        check_val("seq_restart_data", frame_data, exp_frame(400, 1));
        check_val("seq_restart_ncl", frame_nclusters, 8);

        // Saturation: 300 stray pass-5 results in IDLE.
        for (int k = 0; k < 300; k++) send(5, 1'b1, 1, 1);
        idle();
        check_val("sat_seq", seq_err_cnt, 255);
        check_val("sat_ovf_kept", overflow_cnt, 1);

        // Reset mid-frame with a held output frame.
        frame_ready = 1'b0;
        send_frame(500, 1);
        check_val("rst_held_valid", frame_valid, 1);
        for (int k = 0; k < 5; k++) send(k, 1'b1, 600 + k, k);
        idle();
        #2 reset_n = 1'b0;
        #1;
        check_val("rst_async_valid", frame_valid, 0);
        check_val("rst_async_data", frame_data, inv_frame());
        check_val("rst_async_ncl", frame_nclusters, 0);
        check_val("rst_async_ovf", overflow_cnt, 0);
        check_val("rst_async_seq", seq_err_cnt, 0);
        @(negedge clock);
        reset_n = 1'b1;
        frame_ready = 1'b1;
        send_frame(20, 3);
        check_val("post_rst_valid", frame_valid, 1);
        check_val("post_rst_data", frame_data, exp_frame(20, 3));
        check_val("post_rst_ncl", frame_nclusters, 8);
        check_val("post_rst_seq", seq_err_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
